// File: rtl/cpu_bus_master.sv
// 6502-style bus initiator: turns a valid/ready command stream into phi2-timed
// bus cycles, with AEC handback, RDY read stretching and a one-entry command buffer.
module cpu_bus_master #(
  parameter int unsigned HALF_PERIOD = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        _reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_write,
  output logic [7:0]  rsp_rdata,
  output logic        busy,
  output logic        phi2,
  output logic [15:0] address,
  output logic        r_w,
  inout  wire  [7:0]  data,
  input  logic        aec,
  input  logic        rdy
);

  typedef enum logic [1:0] {S_IDLE, S_CYCLE, S_ABORT} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phi2_q, phi2_d;
  logic             buf_full_q, buf_write_q;
  logic [15:0]      buf_addr_q;
  logic [7:0]       buf_wdata_q;
  logic             cyc_write_q;
  logic [15:0]      addr_q;
  logic             rw_q;
  logic [7:0]       wdata_q, dout_q;
  logic             drive_q, hold_q;
  logic             rsp_valid_q, rsp_write_q;
  logic [7:0]       rsp_rdata_q;

  logic tc, rise_evt, fall_evt;
  logic cyc_abort, cyc_stall, cyc_done;

  always_comb begin
    tc        = (cnt_q == CNT_W'(HALF_PERIOD - 1));
    rise_evt  = tc & ~phi2_q;
    fall_evt  = tc & phi2_q;
    cnt_d     = tc ? '0 : cnt_q + 1'b1;
    phi2_d    = tc ? ~phi2_q : phi2_q;
    cyc_abort = (state_q == S_CYCLE) & ~aec;
    cyc_stall = (state_q == S_CYCLE) & aec & ~cyc_write_q & ~rdy;
    cyc_done  = (state_q == S_CYCLE) & aec & ~cyc_stall;
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      phi2_q      <= 1'b0;
      buf_full_q  <= 1'b0;
      buf_write_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_wdata_q <= '0;
      cyc_write_q <= 1'b0;
      addr_q      <= '0;
      rw_q        <= 1'b1;
      wdata_q     <= '0;
      dout_q      <= '0;
      drive_q     <= 1'b0;
      hold_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      phi2_q      <= phi2_d;
      rsp_valid_q <= 1'b0;

      if (hold_q) begin
        drive_q <= 1'b0;
        hold_q  <= 1'b0;
      end

      if (cmd_valid && !buf_full_q) begin
        buf_full_q  <= 1'b1;
        buf_write_q <= cmd_write;
        buf_addr_q  <= cmd_addr;
        buf_wdata_q <= cmd_wdata;
      end

      if (rise_evt && state_q == S_CYCLE) begin
        if (!aec) begin
          state_q <= S_ABORT;
          rw_q    <= 1'b1;
        end else if (cyc_write_q) begin
          drive_q <= 1'b1;
          dout_q  <= wdata_q;
        end
      end

      if (fall_evt) begin
        if (cyc_done) begin
          rsp_valid_q <= 1'b1;
          rsp_write_q <= cyc_write_q;
          if (!cyc_write_q) rsp_rdata_q <= data;
        end
        // Write data is held one clk past the boundary from dout_q, so the
        // launch below may reload wdata_q without disturbing the bus.
        if (cyc_abort) drive_q <= 1'b0;
        else if (drive_q) hold_q <= 1'b1;

        if (!cyc_stall) begin
          if (aec && state_q == S_ABORT) begin
            state_q <= S_CYCLE;
            rw_q    <= ~cyc_write_q;
          end else if (aec && buf_full_q) begin
            state_q     <= S_CYCLE;
            cyc_write_q <= buf_write_q;
            addr_q      <= buf_addr_q;
            wdata_q     <= buf_wdata_q;
            rw_q        <= ~buf_write_q;
            buf_full_q  <= 1'b0;
          end else begin
            rw_q    <= 1'b1;
            state_q <= (state_q == S_ABORT || cyc_abort) ? S_ABORT : S_IDLE;
          end
        end
      end
    end
  end

  assign cmd_ready = ~buf_full_q;
  assign busy      = buf_full_q | (state_q != S_IDLE);
  assign phi2      = phi2_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign address   = aec ? addr_q : 16'hzzzz;
  assign r_w       = aec ? rw_q : 1'bz;
  assign data      = (aec && drive_q) ? dout_q : 8'hzz;

endmodule

// File: tb/tb_cpu_bus_master.sv
// Directed bench for cpu_bus_master: write, stalled read, AEC abort,
// back-to-back stream, idle bus and mid-cycle reset at HALF_PERIOD=4.
module tb_cpu_bus_master;

  logic        clk = 1'b0;
  logic        _reset;
  logic        cmd_valid, cmd_write;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        aec, rdy;
  logic        cmd_ready, rsp_valid, rsp_write, busy, phi2;
  logic [7:0]  rsp_rdata;
  wire  [15:0] address;
  wire         r_w;
  wire  [7:0]  data;

  logic        flt_en;
  logic [7:0]  slv_val;
  int          checks = 0;
  int          errors = 0;
  int          rsp_cnt = 0;
  int          base;

  // Video chip owns address/r_w while aec=0; a slave returns slv_val during
  // phi2-high of read cycles; flt_en drives a marker to prove the master is off.
  assign address = aec ? 16'hzzzz : 16'h1234;
  assign r_w     = aec ? 1'bz : 1'b0;
  assign data    = flt_en ? 8'h5A : ((phi2 === 1'b1 && r_w === 1'b1) ? slv_val : 8'hzz);

  cpu_bus_master #(.HALF_PERIOD(4), .CNT_W(8)) dut (
    .clk(clk), ._reset(_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .busy(busy), .phi2(phi2), .address(address), .r_w(r_w), .data(data),
    .aec(aec), .rdy(rdy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rsp_valid === 1'b1) rsp_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_fall(input string tag);
    logic prev;
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      prev = phi2;
      tick();
      if (prev === 1'b1 && phi2 === 1'b0) seen = 1'b1;
    end
    chk({tag, "_reached"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_rise(input string tag);
    logic prev;
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      prev = phi2;
      tick();
      if (prev === 1'b0 && phi2 === 1'b1) seen = 1'b1;
    end
    chk({tag, "_reached"}, 32'(seen), 32'd1);
  endtask

  task automatic push_cmd(input logic w, input logic [15:0] a, input logic [7:0] d);
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    for (int i = 0; i < 40 && cmd_ready !== 1'b1; i++) tick();
    chk("push_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    _reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    aec = 1'b1; rdy = 1'b1; flt_en = 1'b1; slv_val = 8'h00;
    #2 _reset = 1'b0;
    #2;
    chk("rst_phi2", 32'(phi2), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_write", 32'(rsp_write), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'h00);
    chk("rst_address", 32'(address), 32'h0000);
    chk("rst_r_w", 32'(r_w), 32'd1);
    chk("rst_data_z", 32'(data), 32'h5A);
    tick(); tick(); tick();
    _reset = 1'b1;

    // Write D020 <- 05
    push_cmd(1'b1, 16'hD020, 8'h05);
    chk("w_cmd_ready_full", 32'(cmd_ready), 32'd0);
    chk("w_busy", 32'(busy), 32'd1);
    wait_fall("w_launch");
    chk("w_launch_addr", 32'(address), 32'hD020);
    chk("w_launch_rw", 32'(r_w), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("w_addr_lo", 32'(address), 32'hD020);
      chk("w_rw_lo", 32'(r_w), 32'd0);
      chk("w_data_z_lo", 32'(data), 32'h5A);
    end
    flt_en = 1'b0;
    for (int i = 4; i <= 8; i++) begin
      tick();
      if (i == 4) chk("w_rise_phi2", 32'(phi2), 32'd1);
      chk("w_addr_hi", 32'(address), 32'hD020);
      chk("w_data", 32'(data), 32'h05);
      if (i < 8) chk("w_rw_hi", 32'(r_w), 32'd0);
    end
    chk("w_fall_phi2", 32'(phi2), 32'd0);
    chk("w_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("w_rsp_write", 32'(rsp_write), 32'd1);
    chk("w_idle_rw", 32'(r_w), 32'd1);
    flt_en = 1'b1;
    tick();
    chk("w_hold_end_z", 32'(data), 32'h5A);
    chk("w_rsp_pulse_end", 32'(rsp_valid), 32'd0);
    chk("w_busy_done", 32'(busy), 32'd0);
    chk("w_rsp_count", 32'(rsp_cnt), 32'd1);

    // Read FFFC with two stalled phi2 periods, then buffered read 1234
    flt_en = 1'b0; slv_val = 8'h4C;
    push_cmd(1'b0, 16'hFFFC, 8'h00);
    wait_fall("r_launch");
    chk("r_launch_addr", 32'(address), 32'hFFFC);
    chk("r_launch_rw", 32'(r_w), 32'd1);
    rdy = 1'b0;
    base = rsp_cnt;
    push_cmd(1'b0, 16'h1234, 8'h00);
    chk("r_buf_full", 32'(cmd_ready), 32'd0);
    wait_fall("r_stall1");
    chk("r_stall1_addr", 32'(address), 32'hFFFC);
    chk("r_stall1_rsp", 32'(rsp_valid), 32'd0);
    chk("r_stall1_no_launch", 32'(cmd_ready), 32'd0);
    wait_fall("r_stall2");
    chk("r_stall2_addr", 32'(address), 32'hFFFC);
    chk("r_stall2_rsp", 32'(rsp_valid), 32'd0);
    rdy = 1'b1;
    wait_fall("r_done");
    chk("r_done_valid", 32'(rsp_valid), 32'd1);
    chk("r_done_write", 32'(rsp_write), 32'd0);
    chk("r_done_rdata", 32'(rsp_rdata), 32'h4C);
    chk("r_next_addr", 32'(address), 32'h1234);
    chk("r_next_ready", 32'(cmd_ready), 32'd1);
    slv_val = 8'h99;
    tick();
    chk("r_pulse_end", 32'(rsp_valid), 32'd0);
    chk("r_single_rsp", 32'(rsp_cnt - base), 32'd1);
    wait_fall("r2_done");
    chk("r2_valid", 32'(rsp_valid), 32'd1);
    chk("r2_rdata", 32'(rsp_rdata), 32'h99);

    // AEC abort of write 0400 <- 3C during phi2-high, then re-issue
    push_cmd(1'b1, 16'h0400, 8'h3C);
    wait_fall("a_launch");
    chk("a_launch_addr", 32'(address), 32'h0400);
    chk("a_launch_rw", 32'(r_w), 32'd0);
    wait_rise("a_rise");
    chk("a_rise_data", 32'(data), 32'h3C);
    base = rsp_cnt;
    tick();
    aec = 1'b0; flt_en = 1'b1;
    #1;
    chk("a_addr_z", 32'(address), 32'h1234);
    chk("a_data_z", 32'(data), 32'h5A);
    wait_fall("a_fall");
    chk("a_no_rsp", 32'(rsp_valid), 32'd0);
    chk("a_busy", 32'(busy), 32'd1);
    chk("a_addr_z2", 32'(address), 32'h1234);
    chk("a_rw_z", 32'(r_w), 32'd0);
    tick(); tick();
    aec = 1'b1; flt_en = 1'b0;
    #1;
    chk("a_wait_rw", 32'(r_w), 32'd1);
    chk("a_wait_addr", 32'(address), 32'h0400);
    wait_fall("a_relaunch");
    chk("a_re_addr", 32'(address), 32'h0400);
    chk("a_re_rw", 32'(r_w), 32'd0);
    chk("a_re_no_rsp", 32'(rsp_cnt - base), 32'd0);
    wait_rise("a_re_rise");
    chk("a_re_data", 32'(data), 32'h3C);
    wait_fall("a_done");
    chk("a_done_valid", 32'(rsp_valid), 32'd1);
    chk("a_done_write", 32'(rsp_write), 32'd1);
    tick();
    chk("a_single_rsp", 32'(rsp_cnt - base), 32'd1);

    // Back-to-back: write 0100, read 0200, write 0300
    slv_val = 8'hA7;
    base = rsp_cnt;
    push_cmd(1'b1, 16'h0100, 8'h11);
    chk("b_ready_full1", 32'(cmd_ready), 32'd0);
    wait_fall("b_f1");
    chk("b_f1_addr", 32'(address), 32'h0100);
    chk("b_f1_rw", 32'(r_w), 32'd0);
    push_cmd(1'b0, 16'h0200, 8'h00);
    chk("b_ready_full2", 32'(cmd_ready), 32'd0);
    wait_fall("b_f2");
    chk("b_f2_rsp", 32'(rsp_valid), 32'd1);
    chk("b_f2_rsp_write", 32'(rsp_write), 32'd1);
    chk("b_f2_addr", 32'(address), 32'h0200);
    chk("b_f2_rw", 32'(r_w), 32'd1);
    push_cmd(1'b1, 16'h0300, 8'h33);
    wait_fall("b_f3");
    chk("b_f3_rsp", 32'(rsp_valid), 32'd1);
    chk("b_f3_rsp_write", 32'(rsp_write), 32'd0);
    chk("b_f3_rdata", 32'(rsp_rdata), 32'hA7);
    chk("b_f3_addr", 32'(address), 32'h0300);
    chk("b_f3_rw", 32'(r_w), 32'd0);
    wait_fall("b_f4");
    chk("b_f4_rsp", 32'(rsp_valid), 32'd1);
    chk("b_f4_rsp_write", 32'(rsp_write), 32'd1);
    chk("b_f4_rw", 32'(r_w), 32'd1);
    tick();
    chk("b_busy_done", 32'(busy), 32'd0);
    chk("b_rsp_count", 32'(rsp_cnt - base), 32'd3);

    // Idle bus
    flt_en = 1'b1;
    base = rsp_cnt;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("i_rw", 32'(r_w), 32'd1);
      chk("i_addr", 32'(address), 32'h0300);
      chk("i_data_z", 32'(data), 32'h5A);
      chk("i_busy", 32'(busy), 32'd0);
    end
    chk("i_no_rsp", 32'(rsp_cnt - base), 32'd0);

    // Reset during phi2-high of a read, with a command buffered
    flt_en = 1'b0; slv_val = 8'h55;
    push_cmd(1'b0, 16'h5555, 8'h00);
    wait_fall("x_launch");
    chk("x_launch_addr", 32'(address), 32'h5555);
    push_cmd(1'b0, 16'h6666, 8'h00);
    wait_rise("x_rise");
    tick();
    base = rsp_cnt;
    _reset = 1'b0;
    #1;
    chk("x_phi2", 32'(phi2), 32'd0);
    chk("x_addr", 32'(address), 32'h0000);
    chk("x_rw", 32'(r_w), 32'd1);
    chk("x_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("x_busy", 32'(busy), 32'd0);
    chk("x_rsp_write", 32'(rsp_write), 32'd0);
    chk("x_rsp_rdata", 32'(rsp_rdata), 32'h00);
    tick(); tick();
    _reset = 1'b1;
    wait_fall("x_post");
    chk("x_post_addr", 32'(address), 32'h0000);
    chk("x_post_rw", 32'(r_w), 32'd1);
    chk("x_post_busy", 32'(busy), 32'd0);
    chk("x_no_rsp", 32'(rsp_cnt - base), 32'd0);
    slv_val = 8'h3E;
    push_cmd(1'b0, 16'h7777, 8'h00);
    wait_fall("x_new_launch");
    chk("x_new_addr", 32'(address), 32'h7777);
    chk("x_new_rw", 32'(r_w), 32'd1);
    wait_fall("x_new_done");
    chk("x_new_valid", 32'(rsp_valid), 32'd1);
    chk("x_new_write", 32'(rsp_write), 32'd0);
    chk("x_new_rdata", 32'(rsp_rdata), 32'h3E);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cpu_bus_master.md
Name: cpu_bus_master

Overview:
- Synthesisable 6502-style bus initiator: turns a valid/ready command stream (address, read/write, write data) into phi2-timed bus cycles on a 16-bit address / 8-bit data CPU bus.
- Drives the CPU-side socket of the 7501 bridge for bring-up, and acts as the master in bench environments.
- Honours AEC (bus handback to the video chip) and RDY (read wait states).
- Returns read data and completion pulses to the command side.

Parameters:
- HALF_PERIOD, 4: system clocks per phi2 half-phase; legal minimum is 2.
- CNT_W, 8: width of the phase counter; must satisfy 2^CNT_W > HALF_PERIOD.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- _reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  one-entry command buffer is empty.
- cmd_write  input  1  1 = write cycle, 0 = read cycle.
- cmd_addr  input  16  cycle address.
- cmd_wdata  input  8  write data.
- rsp_valid  output  1  one-clk pulse when a launched cycle completes.
- rsp_write  output  1  type of the completed cycle; valid with rsp_valid.
- rsp_rdata  output  8  sampled read data; valid with rsp_valid on reads.
- busy  output  1  a command is buffered or a cycle is in flight.
- phi2  output  1  generated bus clock; free-running.
- address  output  16  bus address; high-Z when aec=0.
- r_w  output  1  1 = read, 0 = write; high-Z when aec=0.
- data  inout  8  bus data; driven only during write windows.
- aec  input  1  1 = this master owns the bus.
- rdy  input  1  0 = extend the current read cycle.

Behaviour:
- Reset (_reset=0, async):
  - phi2=0 and phase counter=0.
  - Address register=16'h0000, r_w register=1, data drive disabled.
  - Command buffer emptied, so cmd_ready=1. rsp_valid=0, rsp_write=0, rsp_rdata=8'h00, busy=0.
  - A reset in mid-cycle abandons the cycle: no rsp_valid is produced and the buffered command is lost.
- phi2 generation:
  - The counter counts 0..HALF_PERIOD-1. At terminal count phi2 toggles and the counter returns to 0.
  - rise_evt = terminal count with phi2=0. fall_evt = terminal count with phi2=1.
  - phi2 keeps running whether or not any command is pending.
- Command buffer:
  - One entry; a transfer occurs when cmd_valid and cmd_ready are both high.
  - cmd_ready = buffer empty. It rises on the clk after the buffered command launches.
- Cycle boundary = fall_evt edge. On this edge, in order:
  - (a) Complete the in-flight cycle, if there is one.
  - (b) Launch the next cycle: if the buffer is full and aec=1, load address/r_w/wdata from the buffer and empty it. Otherwise run an idle cycle: r_w=1, address holds its last value (dummy read), and no response is generated.
- Read completion:
  - Sample data into rsp_rdata on the fall_evt edge and pulse rsp_valid with rsp_write=0 for one clk.
  - If rdy=0 on that edge, do not complete. The same read repeats for another full phi2 cycle with identical address and no launch. Repeat until rdy=1.
- Write completion:
  - rsp_valid pulses with rsp_write=1 on the fall_evt edge. rsp_rdata is unchanged.
  - rdy is ignored on writes.
- Write data window:
  - data is driven from the rise_evt edge through one clk after the fall_evt edge (one clk of hold).
  - data is high-Z at all other times and on every read or idle cycle.
- AEC:
  - address, r_w and data are combinationally high-Z whenever aec=0.
  - If aec is 0 at any fall_evt or rise_evt edge during an in-flight cycle, that cycle is aborted without a response. Its command is re-launched, unchanged, at the next fall_evt with aec=1, ahead of the buffered command.
- busy = buffer full OR cycle in flight OR an aborted command is awaiting re-launch.
- Throughput: at most one bus cycle per phi2 period. Back-to-back commands run on consecutive phi2 periods only if the next command is buffered before the launching fall_evt.

Test Plan (HALF_PERIOD=4):
- Write: cmd 16'hD020 wdata 8'h05 -> next fall_evt launches it. address=D020 and r_w=0 for 8 clks. data=05 from rise_evt until 1 clk after fall_evt. rsp_valid=1 with rsp_write=1 once.
- Read with wait states: cmd read 16'hFFFC, bus returns 8'h4C, rdy=0 for two phi2 periods -> address stays FFFC for 3 periods. A single rsp_valid occurs with rsp_rdata=4C. No new launch during the stall.
- AEC abort: aec=0 during phi2-high of a write to 16'h0400 -> bus is high-Z immediately with no response. When aec=1 returns, the write re-issues and completes once with 0400/data.
- Back-to-back: three buffered commands fed at cmd_ready -> three consecutive phi2 periods carry them. cmd_ready is low while the buffer is full. Exactly three rsp_valid pulses occur, in order.
- Idle: no commands -> r_w=1, address holds its last value, data is high-Z, rsp_valid never pulses, busy=0.
- Reset mid-cycle: assert _reset during phi2-high of a read -> all outputs take their reset values immediately, with no rsp_valid. After release, a new command executes normally.
